// File: rtl/bcd_digit_counter.sv
// Two-digit BCD up/down counter with prescaled auto-count, manual step and checked parallel load.
// Optional STEP_SYNC_EN: step goes through a 2-flop synchronizer and a rising-edge detector.
module bcd_digit_counter #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tick,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          tick_i;
  logic          step_evt;
  logic          count_evt;
  logic          load_ok;
  logic [3:0]    ld_ones;
  logic [3:0]    ld_tens;
  logic [3:0]    ones_nxt;
  logic [3:0]    tens_nxt;
  logic          wrap_nxt;

`ifdef STEP_SYNC_EN
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_evt = s2 & ~s3;
`else
  assign step_evt = step;
`endif

  assign ld_ones = load_val[3:0];
  assign ld_tens = load_val[7:4];

  always_comb begin
    tick_i    = 1'b0;
    presc_nxt = presc;
    if (enable) begin
      if (presc == PRESC_LAST) begin
        tick_i    = 1'b1;
        presc_nxt = '0;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  // A simultaneous tick and step merge into a single count.
  assign count_evt = tick_i | step_evt;

  always_comb begin
    load_ok = 1'b1;
    if (ld_ones > 4'd9 || ld_tens > 4'd9)
      load_ok = 1'b0;
    else if (ld_tens > MAX_T || (ld_tens == MAX_T && ld_ones > MAX_O))
      load_ok = 1'b0;
  end

  // Digit-wise BCD step; no binary intermediate.
  always_comb begin
    ones_nxt = ones;
    tens_nxt = tens;
    wrap_nxt = 1'b0;
    if (up) begin
      if (tens == MAX_T && ones == MAX_O) begin
        ones_nxt = '0;
        tens_nxt = '0;
        wrap_nxt = 1'b1;
      end else if (ones == 4'd9) begin
        ones_nxt = '0;
        tens_nxt = tens + 4'd1;
      end else begin
        ones_nxt = ones + 4'd1;
      end
    end else begin
      if (tens == 4'd0 && ones == 4'd0) begin
        ones_nxt = MAX_O;
        tens_nxt = MAX_T;
        wrap_nxt = 1'b1;
      end else if (ones == 4'd0) begin
        ones_nxt = 4'd9;
        tens_nxt = tens - 4'd1;
      end else begin
        ones_nxt = ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones     <= '0;
      tens     <= '0;
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // Load pre-empts any count this cycle; a rejected load also holds the prescaler.
        if (load_ok) begin
          ones  <= ld_ones;
          tens  <= ld_tens;
          presc <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        presc <= presc_nxt;
        if (count_evt) begin
          ones <= ones_nxt;
          tens <= tens_nxt;
          tick <= 1'b1;
          wrap <= wrap_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Directed self-checking bench for bcd_digit_counter (TICK_DIV=4, MAX_COUNT=59, default step mode).
module tb_bcd_digit_counter;

  logic       clk = 1'b0;
  logic       reset, enable, up, load, step;
  logic [7:0] load_val;
  logic [3:0] ones, tens;
  logic       tick, wrap, load_err;

  int checks = 0;
  int errors = 0;

  bcd_digit_counter #(.TICK_DIV(4), .MAX_COUNT(59)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_val(load_val), .step(step), .ones(ones), .tens(tens),
    .tick(tick), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] cnt, input logic t, input logic w,
                         input logic e);
    chk({tag, ".cnt"}, {tens, ones}, cnt);
    chk({tag, ".tick"}, tick, t);
    chk({tag, ".wrap"}, wrap, w);
    chk({tag, ".lerr"}, load_err, e);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // 1: reset with enable and step active
    reset = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b0; step = 1'b1; load_val = '0;
    cyc();
    chk_out("rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("rst2", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; step = 1'b0;

    // 2: auto count up for 40 cycles, tick every 4th
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("auto.tick", tick, (k % 4 == 0) ? 1 : 0);
      chk("auto.cnt", {tens, ones}, ((k / 4) / 10) * 16 + (k / 4) % 10);
      chk("auto.bcd", (ones <= 4'd9 && tens <= 4'd9) ? 1 : 0, 1);
    end
    chk_out("auto.end", 8'h10, 1'b1, 1'b0, 1'b0);

    // 3: load 59, then wrap up to 00 on the next tick
    do_load(8'h59);
    chk_out("ld59", 8'h59, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    chk_out("pre_wrap", 8'h59, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("wrap_up", 8'h00, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("wrap_up+1", 8'h00, 1'b0, 1'b0, 1'b0);

    // 4: load 00, let prescaler reach 2, freeze, step down to 59
    do_load(8'h00);
    chk_out("ld00", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    enable = 1'b0; up = 1'b0; step = 1'b1;
    cyc();
    chk_out("wrap_dn", 8'h59, 1'b1, 1'b1, 1'b0);
    step = 1'b0;
    cyc();
    chk_out("wrap_dn+1", 8'h59, 1'b0, 1'b0, 1'b0);
    enable = 1'b1; up = 1'b1;
    cyc();
    chk_out("frozen.p3", 8'h59, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("frozen.tick", 8'h00, 1'b1, 1'b1, 1'b0);

    // 5: rejected loads, then load coincident with tick
    enable = 1'b0;
    do_load(8'h3A);
    chk_out("rej3A", 8'h00, 1'b0, 1'b0, 1'b1);
    do_load(8'h60);
    chk_out("rej60", 8'h00, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("rej.idle", 8'h00, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(); cyc(); cyc();
    chk_out("ldtick.pre", 8'h00, 1'b0, 1'b0, 1'b0);
    do_load(8'h25);
    chk_out("ldtick", 8'h25, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    chk_out("ldtick.p3", 8'h25, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("ldtick.next", 8'h26, 1'b1, 1'b0, 1'b0);

    // 6: step in the tick cycle counts once
    cyc(); cyc(); cyc();
    chk_out("coin.pre", 8'h26, 1'b0, 1'b0, 1'b0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk_out("coin", 8'h27, 1'b1, 1'b0, 1'b0);

    // down across a ones borrow and back up across a carry
    enable = 1'b0;
    do_load(8'h30);
    up = 1'b0; step = 1'b1;
    cyc();
    chk_out("borrow", 8'h29, 1'b1, 1'b0, 1'b0);
    up = 1'b1;
    cyc();
    step = 1'b0;
    chk_out("carry", 8'h30, 1'b1, 1'b0, 1'b0);

    // reset mid-count, next tick 4 cycles after release
    enable = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    chk_out("midrst.p3", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("midrst.tick", 8'h01, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
